// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Bits needed to hold the values 0..depth inclusive (occupancy/level width)
  function automatic int clog2p1(input int depth);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth + 1) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one read port with a registered
// read. No reset; contents survive a controller reset and are simply ignored.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Wr_En,
  input  logic [AW-1:0]    i_Wr_Addr,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic             i_Rd_En,
  input  logic [AW-1:0]    i_Rd_Addr,
  output logic [WIDTH-1:0] o_Rd_Data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write port
  always_ff @(posedge i_Clk) begin
    if (i_Wr_En) mem_q[i_Wr_Addr] <= i_Wr_Data;
  end

  // Registered read port; holds its value when not enabled
  always_ff @(posedge i_Clk) begin
    if (i_Rd_En) rd_data_q <= mem_q[i_Rd_Addr];
  end

  assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with registered-read or first-word-fall-through
// output, occupancy count and programmable almost-full/almost-empty flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags and i_Err_Clr.
//
// Handshake: a write transfers on i_Wr_DV && !o_Full; a read transfers on
// i_Rd_En && !o_Empty. Rejected requests change no state and produce no
// o_Rd_DV.
//
// Read path is two stages: the RAM read register (s1) and the output register.
// Registered mode: an accepted read fetches into s1, and s1 moves to the output
// register on the next edge, giving a one-cycle o_Rd_DV pulse.
// FWFT mode: words are prefetched from RAM into s1 and on into the output
// register whenever it is free, so o_Rd_DV is a level and pops stream with no
// bubble.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int FWFT  = FIFO_MODE_REG,
  parameter int CW    = clog2p1(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Wr_DV,
  input  logic [WIDTH-1:0] i_Wr_Data,
  output logic             o_Full,
  input  logic             i_Rd_En,
  output logic             o_Rd_DV,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Empty,
  output logic [CW-1:0]    o_Count,
  input  logic [CW-1:0]    i_AF_Level,
  input  logic [CW-1:0]    i_AE_Level,
`ifdef SYNC_FIFO_ERR_EN
  input  logic             i_Err_Clr,
  output logic             o_Overflow,
  output logic             o_Underflow,
`endif
  output logic             o_AF_Flag,
  output logic             o_AE_Flag
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;          // words visible to the user
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;  // words still inside the RAM
  logic             s1_vld_q, s1_vld_d;    // RAM read register holds a word
  logic             rd_dv_q, rd_dv_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] ram_rd_data;

  logic wr_acc;    // accepted write this cycle
  logic rd_acc;    // accepted user read / pop this cycle
  logic fetch;     // RAM read issued this cycle
  logic out_free;  // output register can take a new word this cycle
  logic out_load;  // s1 moves into the output register this cycle

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_Clk     (i_Clk),
    .i_Wr_En   (wr_acc),
    .i_Wr_Addr (wr_ptr_q),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_En   (fetch),
    .i_Rd_Addr (rd_ptr_q),
    .o_Rd_Data (ram_rd_data)
  );

  assign o_Full    = (cnt_q == DEPTH_C);
  assign o_Empty   = (FWFT == FIFO_MODE_FWFT) ? !rd_dv_q : (cnt_q == '0);
  assign o_Count   = cnt_q;
  assign o_Rd_DV   = rd_dv_q;
  assign o_Rd_Data = rd_data_q;
  assign o_AF_Flag = (cnt_q >= i_AF_Level);
  assign o_AE_Flag = (cnt_q <= i_AE_Level);

  // Acceptance, read-pipeline movement and next-state arithmetic
  always_comb begin
    wr_acc = i_Wr_DV && !o_Full;
    rd_acc = i_Rd_En && !o_Empty;

    if (FWFT == FIFO_MODE_FWFT) begin
      out_free = !rd_dv_q || rd_acc;
      out_load = s1_vld_q && out_free;
      // Fetch whenever s1 is empty or is being drained into the output
      fetch    = (mem_cnt_q != '0) && (!s1_vld_q || out_free);
      rd_dv_d  = out_load || (rd_dv_q && !rd_acc);
    end else begin
      out_free = 1'b1;
      out_load = s1_vld_q;
      fetch    = rd_acc;
      rd_dv_d  = s1_vld_q;
    end

    s1_vld_d  = fetch || (s1_vld_q && !out_load);
    rd_data_d = out_load ? ram_rd_data : rd_data_q;

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);

    rd_ptr_d = rd_ptr_q;
    if (fetch) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({wr_acc, fetch})
      2'b10:   mem_cnt_d = mem_cnt_q + CW'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CW'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Controller state; asynchronous reset discards all contents at once
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      mem_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      rd_dv_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      mem_cnt_q <= mem_cnt_d;
      s1_vld_q  <= s1_vld_d;
      rd_dv_q   <= rd_dv_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // Sticky error capture; a new error outranks a clear in the same cycle
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (i_Wr_DV && o_Full)       ovf_q <= 1'b1;
      else if (i_Err_Clr)          ovf_q <= 1'b0;
      if (i_Rd_En && o_Empty)      udf_q <= 1'b1;
      else if (i_Err_Clr)          udf_q <= 1'b0;
    end
  end

  assign o_Overflow  = ovf_q;
  assign o_Underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl. Three instances share one stimulus stream:
// DEPTH=4 registered, DEPTH=5 registered, DEPTH=5 FWFT. Each has its own
// queue-based reference model and monitor.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  localparam int W   = 8;
  localparam int CWT = 3;

  typedef struct {
    logic [W-1:0] data;
    int           ready;  // first edge after which FWFT may present this word
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           wr_dv, rd_en, err_clr;
  logic [W-1:0]   wr_data;
  logic [CWT-1:0] af_lvl, ae_lvl;
  int             n_checks = 0;
  int             n_errs = 0;

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s inst%0d: actual %0h required %0h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, away from the active edge
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    #1;
    wr_dv   = w;
    wr_data = d;
    rd_en   = r;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : 5;
    localparam int F = (g == 2) ? FIFO_MODE_FWFT : FIFO_MODE_REG;

    logic           full, dv, empty, af, ae;
    logic [W-1:0]   rdata;
    logic [CWT-1:0] cnt;
`ifdef SYNC_FIFO_ERR_EN
    logic           ovf, udf;
`endif

    sync_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .FWFT(F)) u_dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_Wr_DV     (wr_dv),
      .i_Wr_Data   (wr_data),
      .o_Full      (full),
      .i_Rd_En     (rd_en),
      .o_Rd_DV     (dv),
      .o_Rd_Data   (rdata),
      .o_Empty     (empty),
      .o_Count     (cnt),
      .i_AF_Level  (af_lvl),
      .i_AE_Level  (ae_lvl),
`ifdef SYNC_FIFO_ERR_EN
      .i_Err_Clr   (err_clr),
      .o_Overflow  (ovf),
      .o_Underflow (udf),
`endif
      .o_AF_Flag   (af),
      .o_AE_Flag   (ae)
    );

    item_t        mdl_q[$];   // words held, oldest first
    logic [W-1:0] exp_q[$];   // registered mode: words read, awaiting o_Rd_DV
    int           edge_n = 0;
    logic         pend1 = 1'b0, pend_dv = 1'b0;
    logic         m_ovf = 1'b0, m_udf = 1'b0;
    logic [W-1:0] last_rd = '0;

    // Reference model: queue of words; acceptance from the occupancy rules
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mdl_q.delete();
        exp_q.delete();
        pend1   = 1'b0;
        pend_dv = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
      end else begin : m_step
        logic m_head, m_full, m_empty, wr_ok, rd_ok;
        m_head  = (mdl_q.size() > 0) && (edge_n >= mdl_q[0].ready);
        m_full  = (mdl_q.size() == D);
        m_empty = (F == FIFO_MODE_FWFT) ? !m_head : (mdl_q.size() == 0);
        wr_ok   = wr_dv && !m_full;
        rd_ok   = rd_en && !m_empty;
        if (wr_dv && m_full) m_ovf = 1'b1;
        else if (err_clr)    m_ovf = 1'b0;
        if (rd_en && m_empty) m_udf = 1'b1;
        else if (err_clr)     m_udf = 1'b0;
        edge_n++;
        pend_dv = pend1;
        pend1   = rd_ok && (F == FIFO_MODE_REG);
        if (rd_ok) begin
          if (F == FIFO_MODE_REG) exp_q.push_back(mdl_q[0].data);
          void'(mdl_q.pop_front());
        end
        if (wr_ok) mdl_q.push_back('{data: wr_data, ready: edge_n + 2});
      end
    end

    // Monitor: compare DUT outputs against the model between edges
    always @(negedge clk) begin
      if (!rst_n) begin
        last_rd = '0;
      end else begin : mon
        int   sz;
        logic hd;
        sz = mdl_q.size();
        hd = (sz > 0) && (edge_n >= mdl_q[0].ready);
        check("count", g, cnt, sz);
        check("full", g, full, sz == D);
        check("af_flag", g, af, sz >= af_lvl);
        check("ae_flag", g, ae, sz <= ae_lvl);
        check("empty", g, empty, (F == FIFO_MODE_FWFT) ? !hd : (sz == 0));
        check("rd_dv", g, dv, (F == FIFO_MODE_FWFT) ? hd : pend_dv);
        if (F == FIFO_MODE_FWFT) begin
          if (hd) check("rd_data", g, rdata, mdl_q[0].data);
        end else if (dv) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL rd_data inst%0d: actual %0h required no word (t=%0t)", g, rdata, $time);
          end else begin
            last_rd = exp_q.pop_front();
            check("rd_data", g, rdata, last_rd);
          end
        end else begin
          check("rd_hold", g, rdata, last_rd);
        end
`ifdef SYNC_FIFO_ERR_EN
        check("overflow", g, ovf, m_ovf);
        check("underflow", g, udf, m_udf);
`endif
      end
    end

    // Reset takes effect without waiting for a clock edge
    always @(negedge rst_n) begin
      #1;
      check("rst_full", g, full, 0);
      check("rst_empty", g, empty, 1);
      check("rst_rd_dv", g, dv, 0);
      check("rst_rd_data", g, rdata, 0);
      check("rst_count", g, cnt, 0);
      check("rst_af", g, af, af_lvl == 0);
      check("rst_ae", g, ae, 1);
`ifdef SYNC_FIFO_ERR_EN
      check("rst_overflow", g, ovf, 0);
      check("rst_underflow", g, udf, 0);
`endif
    end
  end

  // Stimulus
  initial begin
    int bias;
    wr_dv = 1'b0; rd_en = 1'b0; wr_data = '0; err_clr = 1'b0;
    af_lvl = 3'd3; ae_lvl = 3'd1;
    bias = 5;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Fill past full, then drain past empty
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'hA1 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    err_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    err_clr = 1'b0;

    // Single word latency, pop, then read on empty
    step(1'b1, 8'h55, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Steady-level write+read pairs across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h10 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, W'(8'h20 + i), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Simultaneous write+read on a full FIFO
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h30 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'h3F, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Reset mid-burst at count 3, then new data only
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h40 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    #1 rst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 8'h66, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Randomized traffic with drifting fill bias and levels
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        bias   = $urandom_range(1, 9);
        af_lvl = CWT'($urandom_range(0, 6));
        ae_lvl = CWT'($urandom_range(0, 6));
      end
      if (i == 1500) begin
        step(1'b1, W'($urandom_range(0, 255)), 1'b0);
        #1 rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 9) < bias, W'($urandom_range(0, 255)),
           $urandom_range(0, 9) >= bias);
      err_clr = ($urandom_range(0, 39) == 0);
    end
    err_clr = 1'b0;
    repeat (4) step(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO for the streaming datapath. Supports any WIDTH/DEPTH and two read modes: registered read and first-word-fall-through (FWFT). Provides an occupancy count, runtime-programmable almost-full/almost-empty thresholds and optional sticky error flags. Sits between producer and consumer stages that share one clock domain.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 256, number of storage words (≥2, need not be a power of two)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- CW, $clog2(DEPTH+1), count/level width (derived, not overridden)

Ports:
- i_Clk  in  1  clock; all logic on rising edge
- i_Rst_L  in  1  reset, asynchronous assert, active-low
- i_Wr_DV  in  1  write request
- i_Wr_Data  in  WIDTH  write data
- o_Full  out  1  count == DEPTH
- i_Rd_En  in  1  read request (FWFT=0) / pop of head word (FWFT=1)
- o_Rd_DV  out  1  o_Rd_Data valid
- o_Rd_Data  out  WIDTH  read data
- o_Empty  out  1  no word available to read
- o_Count  out  CW  words held (FWFT=1: includes word in output register)
- i_AF_Level  in  CW  almost-full threshold
- i_AE_Level  in  CW  almost-empty threshold
- o_AF_Flag  out  1  o_Count >= i_AF_Level
- o_AE_Flag  out  1  o_Count <= i_AE_Level
- i_Err_Clr  in  1  clear sticky errors (SYNC_FIFO_ERR_EN only)
- o_Overflow, o_Underflow  out  1 each  sticky errors (SYNC_FIFO_ERR_EN only)

## Operation
- Write accepted iff i_Wr_DV && !o_Full; rejected writes are dropped, storage and pointers unchanged.
- Read accepted iff i_Rd_En && !o_Empty; rejected reads change nothing; o_Rd_DV not asserted for them.
- Write/read pointers advance by one per accepted op; wrap DEPTH-1 → 0 explicitly.
- Count: +1 on write-only, −1 on read-only, unchanged on simultaneous accepted write+read. Never exceeds DEPTH and never underflows.
- When full, a simultaneous write+read accepts only the read. When empty, it accepts only the write.
- FWFT=0: o_Empty = (count == 0); o_Rd_DV is a one-cycle pulse per accepted read; o_Rd_Data holds its last value otherwise.
- FWFT=1: internal prefetch moves the head word into the output register whenever that register is free. o_Rd_DV is level: high while the head word is presented. o_Empty = !o_Rd_DV. i_Rd_En with o_Rd_DV pops; the next word is presented with no bubble if one is stored.
- o_AF_Flag and o_AE_Flag are combinational from registered count and the level inputs; levels may change at any time.
- Reset values: o_Full 0, o_Empty 1, o_Rd_DV 0, o_Rd_Data 0, o_Count 0, pointers 0, o_Overflow/o_Underflow 0. Flags follow count 0.
- Reset mid-operation discards all contents immediately (asynchronous). Storage RAM is not cleared.

## Timing
- Write at edge k: o_Count, o_Full, o_Empty (FWFT=0) update after edge k.
- FWFT=0 read: i_Rd_En accepted at edge k → o_Rd_DV=1 with data after edge k+1. Latency 1, back-to-back reads at one per cycle.
- FWFT=1: write into empty FIFO at edge k → o_Rd_DV=1 with data after edge k+2. Sustained throughput one word per cycle.
- Full throughput: simultaneous write+read every cycle indefinitely at any fill level 1..DEPTH-1.

## Configuration
- SYNC_FIFO_ERR_EN defined: o_Overflow sets on a rejected write (i_Wr_DV && o_Full). o_Underflow sets on a rejected read (i_Rd_En && o_Empty). Both are sticky until i_Err_Clr is sampled high; set has priority over clear in the same cycle.
- Not defined: the ports i_Err_Clr, o_Overflow and o_Underflow are absent, with no error logic.

## Structure
- Package fifo_pkg: FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1 constants; count-width function clog2p1(DEPTH).
- Sub-module fifo_ram: simple dual-port RAM, one write port and one read port with registered read, on i_Clk, parametrised WIDTH/DEPTH, no reset. The controller holds the pointers, count, prefetch and flags.

## Test plan
- Reset then DEPTH=4, FWFT=0: write 0xA1..0xA4 → o_Full=1, o_Count=4. Fifth write dropped (o_Overflow=1 if enabled). Four reads → data A1..A4, each 1 cycle after its read. o_Empty=1.
- DEPTH=5 (non-power-of-two): 12 write/read pairs → data order preserved across pointer wrap. o_Count stays at its pre-loop value.
- FWFT=1: single write 0x55 at edge k → o_Rd_DV=1, o_Rd_Data=0x55 after edge k+2. Pop → o_Empty=1. Read on empty → no o_Rd_DV (o_Underflow=1 if enabled).
- i_AF_Level=3, i_AE_Level=1, fill 0→4→0 → o_AE_Flag high at counts 0–1, o_AF_Flag high at counts 3–4.
- Full FIFO with write+read in the same cycle → read accepted, write dropped, o_Count=DEPTH−1.
- Assert i_Rst_L low mid-burst at count 3 → outputs at reset values immediately, without waiting for an edge. Subsequent write/read returns new data only.
